md5_engine: RTL and testbench
=============================

# md5_engine

Iterative MD5 compression engine for one 512-bit message block per transaction, with multi-block chaining. Generalises the single-word MD5 datapath into a full 64-step core: UNROLL steps per clock, valid/ready block input, a chaining register and a one-cycle digest-valid pulse. It sits between the message/padding front end and the hash consumer in the MD5 design.

## Interface
- UNROLL, default 1: MD5 steps evaluated per clock; legal values 1, 2, 4. Any other value is a compile-time error.
- clk_i  input  1: single clock, all logic rising-edge.
- rst_i  input  1: reset, synchronous and active-high.
- blk_valid_i  input  1: blk_i/first_i (and msg_len_i) valid.
- blk_ready_o  output  1: engine accepts a block this cycle.
- blk_i  input  512: message block; byte 0 at [511:504], byte 63 at [7:0].
- first_i  input  1: 1 = start from IV, 0 = continue from the chaining register.
- hash_valid_o  output  1: one-cycle pulse, digest on hash_o.
- hash_o  output  128: digest after the block; digest byte 0 at [127:120].
- busy_o  output  1: block in progress.
- msg_len_i  input  6: message byte count 0..55 (only with MD5_PAD_EN).

## Operation
- Word mapping: M[j] = little-endian of bytes 4j..4j+3, so M[0] = {blk_i[487:480], blk_i[495:488], blk_i[503:496], blk_i[511:504]}.
- IV: A=67452301, B=EFCDAB89, C=98BADCFE, D=10325476.
- Steps follow RFC 1321: F/G/H/I per round, K[i] = floor(abs(sin(i+1))·2^32), per-step shifts and message index g (i, 5i+1, 3i+5, 7i mod 16). All adds are mod 2^32; carries are discarded.
- FSM states:
  - IDLE: blk_ready_o=1. On blk_valid_i: latch M[0..15], load working A..D from IV (first_i=1) or from the chain (first_i=0), clear the step counter, go to RUN.
  - RUN: UNROLL steps per cycle; step counter advances by UNROLL. After step 63 completes: chain ← chain_start + A..D (per word, mod 2^32), go to DONE.
  - DONE: hash_valid_o=1 for one cycle, then IDLE.
- hash_o is the chain register with each 32-bit word byte-swapped to digest byte order. It holds until the next completion.
- busy_o = (state != IDLE).

## Timing
- Acceptance cycle T (blk_valid_i & blk_ready_o). RUN occupies T+1 .. T+64/UNROLL.
- hash_valid_o is high at cycle T+64/UNROLL+1.
- blk_ready_o returns at T+64/UNROLL+2, so throughput is one block per 64/UNROLL+2 cycles.
- blk_ready_o is 0 in RUN and DONE. blk_valid_i is ignored there; no block is lost or queued, and the sender holds it.
- Reset values: state IDLE, blk_ready_o=1 (first cycle after reset release), hash_valid_o=0, busy_o=0, hash_o=0. Chain register = IV; hash_o reads 0 until the first completion.
- rst_i mid-RUN aborts the block with no hash_valid_o. The next block with first_i=0 chains from IV.
- first_i=0 after reset behaves as first_i=1.

## Configuration
- MD5_PAD_EN defined:
  - msg_len_i port exists.
  - On acceptance the engine pads internally: bytes 0..len-1 come from blk_i, byte len = 0x80, zeros follow, and words 14/15 carry the 64-bit bit length (len·8) little-endian.
  - first_i is forced to 1.
  - msg_len_i > 55 is treated as 55.
- MD5_PAD_EN undefined: no msg_len_i port; blk_i is used verbatim as a pre-padded block.

## Test plan
- Padded empty string (blk_i = 0x80 then zeros, len 0), first_i=1 -> hash_o = d41d8cd98f00b204e9800998ecf8427e at T+65 (UNROLL=1).
- Padded "abc" (bytes 61 62 63 80 …, word 14 = 0x18) -> 900150983cd24fb0d6963f7d28e17f72. Repeat with UNROLL=2 and 4, expecting valid at T+33 and T+17.
- Two-block "1234567890" ×8 (80 bytes): first_i=1 then first_i=0 -> 57edf4a22be3c955ac49da2e2107b67a. Exactly one hash_valid_o per block.
- Hold blk_valid_i high throughout RUN -> only one acceptance per block period; blk_ready_o low T+1..T+65.
- Assert rst_i at step 30 -> no hash_valid_o, hash_o=0. A following "abc" block with first_i=0 still yields 900150983cd24fb0d6963f7d28e17f72.
- MD5_PAD_EN: blk_i = "The quick brown fox jumps over the lazy dog", msg_len_i=43 -> 9e107d9d372bb6826bd81d3542a419d6.

Source files
------------

// File: rtl/md5_engine.sv
// md5_engine: iterative MD5 compression of one 512-bit block per transaction, UNROLL steps per clock, with chaining.
// Optional `define MD5_PAD_EN: adds msg_len_i and pads a single short (<=55-byte) message internally.
module md5_engine #(
  parameter int UNROLL = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [511:0] blk_i,
  input  logic         first_i,
`ifdef MD5_PAD_EN
  input  logic [5:0]   msg_len_i,
`endif
  output logic         hash_valid_o,
  output logic [127:0] hash_o,
  output logic         busy_o
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("md5_engine: UNROLL must be 1, 2 or 4");
  end

  typedef logic [31:0] word_t;
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
  } abcd_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam abcd_t IV = '{a: 32'h67452301, b: 32'hefcdab89, c: 32'h98badcfe, d: 32'h10325476};
  localparam logic [5:0] LAST_STEP = 6'(64 - UNROLL);

  localparam word_t K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate amounts indexed by {round, step[1:0]}.
  localparam logic [4:0] S_TAB [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic abcd_t md5_step(input abcd_t v, input logic [5:0] i, input logic [15:0][31:0] m);
    word_t       f;
    word_t       t;
    logic [3:0]  ii;
    logic [3:0]  g;
    logic [63:0] rot;
    ii = i[3:0];
    f  = '0;
    g  = ii;
    unique case (i[5:4])
      2'd0: begin f = (v.b & v.c) | (~v.b & v.d); g = ii; end
      2'd1: begin f = (v.b & v.d) | (v.c & ~v.d); g = ii * 4'd5 + 4'd1; end
      2'd2: begin f = v.b ^ v.c ^ v.d;            g = ii * 4'd3 + 4'd5; end
      2'd3: begin f = v.c ^ (v.b | ~v.d);         g = ii * 4'd7;        end
      default: ;
    endcase
    t   = v.a + f + K_TAB[i] + m[g];
    rot = {t, t} << S_TAB[{i[5:4], i[1:0]}];
    return '{a: v.d, b: v.b + rot[63:32], c: v.b, d: v.c};
  endfunction

  function automatic abcd_t run_steps(input abcd_t v, input logic [5:0] base, input logic [15:0][31:0] m);
    abcd_t x;
    x = v;
    for (int u = 0; u < UNROLL; u++) x = md5_step(x, base + 6'(u), m);
    return x;
  endfunction

  function automatic logic [15:0][31:0] to_words(input logic [511:0] b);
    logic [15:0][31:0] m;
    for (int j = 0; j < 16; j++)
      for (int n = 0; n < 4; n++)
        m[j][8*n +: 8] = b[511 - 8*(4*j + n) -: 8];
    return m;
  endfunction

  function automatic word_t bswap(input word_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  state_t            state_q, state_d;
  logic [5:0]        step_q;
  logic [15:0][31:0] msg_q;
  abcd_t             work_q, base_q, chain_q, next_work, start;
  logic              seen_q, accept, last_step, first_eff;
  logic [511:0]      blk_eff;

`ifdef MD5_PAD_EN
  logic [5:0] pad_len;
  logic [8:0] bit_len;
  logic       unused_pad;

  always_comb begin
    pad_len = (msg_len_i > 6'd55) ? 6'd55 : msg_len_i;
    bit_len = {pad_len, 3'b000};
    blk_eff = '0;
    for (int k = 0; k < 56; k++) begin
      if (6'(k) < pad_len)       blk_eff[511 - 8*k -: 8] = blk_i[511 - 8*k -: 8];
      else if (6'(k) == pad_len) blk_eff[511 - 8*k -: 8] = 8'h80;
    end
    blk_eff[511 - 8*56 -: 8] = bit_len[7:0];
    blk_eff[511 - 8*57 -: 8] = {7'd0, bit_len[8]};
  end

  assign first_eff  = 1'b1;
  assign unused_pad = ^{first_i, blk_i[63:0]};
`else
  assign blk_eff   = blk_i;
  assign first_eff = first_i;
`endif

  assign accept    = blk_valid_i & blk_ready_o;
  assign last_step = (step_q == LAST_STEP);
  assign start     = first_eff ? IV : chain_q;
  assign next_work = run_steps(work_q, step_q, msg_q);
  assign busy_o    = (state_q != IDLE);
  assign hash_o    = seen_q ? {bswap(chain_q.a), bswap(chain_q.b), bswap(chain_q.c), bswap(chain_q.d)} : '0;

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    blk_ready_o  = 1'b0;
    hash_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        blk_ready_o = 1'b1;
        if (blk_valid_i) state_d = RUN;
      end
      RUN:  if (last_step) state_d = DONE;
      DONE: begin
        hash_valid_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      chain_q <= IV;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN && last_step) begin
        chain_q <= '{a: base_q.a + next_work.a, b: base_q.b + next_work.b,
                     c: base_q.c + next_work.c, d: base_q.d + next_work.d};
        seen_q  <= 1'b1;
      end
    end
  end

  // NOTE: the block datapath has no reset; every field is loaded on acceptance before it is read.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      msg_q  <= to_words(blk_eff);
      work_q <= start;
      base_q <= start;
      step_q <= '0;
    end else if (state_q == RUN) begin
      work_q <= next_work;
      step_q <= step_q + 6'(UNROLL);
    end
  end

endmodule

// File: tb/tb_md5_engine.sv
// Directed testbench for md5_engine: UNROLL = 1, 2, 4 instances, expected digests queued on acceptance.
module tb_md5_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         first;
  logic [511:0] blk;
  logic [5:0]   msg_len;
  logic         vld [3];
  logic         rdy [3];
  logic         hv  [3];
  logic         bsy [3];
  logic [127:0] hsh [3];

  int           total = 0;
  int           bad   = 0;
  logic [127:0] exp_q [$];

  localparam logic [127:0] H_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] H_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] H_80    = 128'h57edf4a22be3c955ac49da2e2107b67a;
  localparam logic [127:0] H_FOX   = 128'h9e107d9d372bb6826bd81d3542a419d6;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    md5_engine #(.UNROLL(1 << g)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .blk_valid_i (vld[g]),
      .blk_ready_o (rdy[g]),
      .blk_i       (blk),
      .first_i     (first),
`ifdef MD5_PAD_EN
      .msg_len_i   (msg_len),
`endif
      .hash_valid_o(hv[g]),
      .hash_o      (hsh[g]),
      .busy_o      (bsy[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Standard MD5 padding of s starting at byte offset off; add_len appends the 64-bit bit count.
  function automatic logic [511:0] build_blk(input string s, input int off, input bit add_len);
    logic [511:0] b;
    logic [63:0]  bits;
    b = '0;
    for (int k = 0; k < 64; k++) begin
      if (off + k < s.len())       b[511 - 8*k -: 8] = s[off + k];
      else if (off + k == s.len()) b[511 - 8*k -: 8] = 8'h80;
    end
    if (add_len) begin
      bits = 64'(s.len()) * 64'd8;
      for (int k = 0; k < 8; k++) b[511 - 8*(56 + k) -: 8] = bits[8*k +: 8];
    end
    return b;
  endfunction

  // Raw message bytes followed by 0xff filler that internal padding must discard.
  function automatic logic [511:0] raw_blk(input string s);
    logic [511:0] b;
    b = '1;
    for (int k = 0; k < s.len(); k++) b[511 - 8*k -: 8] = s[k];
    return b;
  endfunction

  task automatic send_block(input int idx, input string tag, input logic [511:0] b, input logic f,
                            input logic [5:0] len, input bit chk, input logic [127:0] exp, input bit hold);
    int lat;
    int ready_in_run;
    blk     = b;
    first   = f;
    msg_len = len;
    vld[idx] = 1'b1;
    for (int i = 0; i < 200 && !rdy[idx]; i++) tick();
    check({tag, " accept"}, 128'(rdy[idx]), 128'd1);
    if (!rdy[idx]) begin
      vld[idx] = 1'b0;
      return;
    end
    tick();
    if (chk) exp_q.push_back(exp);
    if (!hold) vld[idx] = 1'b0;
    lat = 1;
    ready_in_run = 0;
    while (!hv[idx] && lat < 200) begin
      if (rdy[idx]) ready_in_run++;
      tick();
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'((64 >> idx) + 1));
    check({tag, " ready low"}, 128'(ready_in_run + int'(rdy[idx])), 128'd0);
    if (chk && exp_q.size() > 0) check({tag, " hash"}, hsh[idx], exp_q.pop_front());
    tick();
    check({tag, " single pulse"}, 128'(hv[idx]), 128'd0);
    check({tag, " ready back"}, 128'(rdy[idx]), 128'd1);
    if (chk) check({tag, " hash hold"}, hsh[idx], exp);
    if (hold) begin
      vld[idx] = 1'b0;
      tick();
      check({tag, " no extra accept"}, 128'(bsy[idx]), 128'd0);
    end
  endtask

  string s_empty = "";
  string s_abc   = "abc";
  string s_fox   = "The quick brown fox jumps over the lazy dog";
  string s_80    = "";
  logic  hv_seen;

  initial begin
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    for (int i = 0; i < 8; i++) s_80 = {s_80, "1234567890"};
    blk     = '0;
    first   = 1'b1;
    msg_len = '0;
    rst     = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset ready", 128'(rdy[0]), 128'd1);
    check("reset hash_valid", 128'(hv[0]), 128'd0);
    check("reset busy", 128'(bsy[0]), 128'd0);
    check("reset hash", hsh[0], 128'd0);
    check("reset hash u4", hsh[2], 128'd0);

    send_block(0, "empty u1", build_blk(s_empty, 0, 1'b1), 1'b1, 6'd0, 1'b1, H_EMPTY, 1'b0);
    send_block(0, "abc u1", build_blk(s_abc, 0, 1'b1), 1'b1, 6'd3, 1'b1, H_ABC, 1'b0);
    send_block(1, "abc u2", build_blk(s_abc, 0, 1'b1), 1'b1, 6'd3, 1'b1, H_ABC, 1'b0);
    send_block(2, "abc u4", build_blk(s_abc, 0, 1'b1), 1'b1, 6'd3, 1'b1, H_ABC, 1'b0);

`ifndef MD5_PAD_EN
    send_block(0, "80B blk1", build_blk(s_80, 0, 1'b0), 1'b1, 6'd0, 1'b0, '0, 1'b0);
    send_block(0, "80B blk2 hold", build_blk(s_80, 64, 1'b1), 1'b0, 6'd0, 1'b1, H_80, 1'b1);
    send_block(0, "abc fresh", build_blk(s_abc, 0, 1'b1), 1'b1, 6'd3, 1'b1, H_ABC, 1'b0);

    blk      = build_blk(s_abc, 0, 1'b1);
    first    = 1'b1;
    vld[0]   = 1'b1;
    tick();
    vld[0]   = 1'b0;
    check("abort started", 128'(bsy[0]), 128'd1);
    hv_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      hv_seen |= hv[0];
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 128'(bsy[0]), 128'd0);
    check("abort hash", hsh[0], 128'd0);
    check("abort ready", 128'(rdy[0]), 128'd1);
    for (int i = 0; i < 80; i++) begin
      hv_seen |= hv[0];
      tick();
    end
    check("abort no valid", 128'(hv_seen), 128'd0);
    send_block(0, "abc chain after rst", build_blk(s_abc, 0, 1'b1), 1'b0, 6'd3, 1'b1, H_ABC, 1'b0);
`else
    send_block(0, "pad fox", raw_blk(s_fox), 1'b0, 6'd43, 1'b1, H_FOX, 1'b0);
    send_block(1, "pad abc", raw_blk(s_abc), 1'b0, 6'd3, 1'b1, H_ABC, 1'b0);
`endif

    check("scoreboard drained", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
